// File: rtl/midi_pkg.sv
// midi_pkg: constants, parser state type and helpers shared by the MIDI note
// controller.
//   - Status nibble constants for the channel-voice messages.
//   - Byte class thresholds (real-time, system common).
//   - Controller numbers that silence the voice.
//   - Parser state enum and the data-length helper.
package midi_pkg;

  // Channel-voice status nibbles (status byte bits [7:4]).
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // Bytes at or above RT_MIN are real-time and transparent to the parser.
  localparam logic [7:0] RT_MIN   = 8'hF8;
  // Bytes from SYS_MIN up to RT_MIN-1 are system common / SysEx.
  localparam logic [7:0] SYS_MIN  = 8'hF0;

  // Controller numbers that release the sounding note.
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  // IDLE: no running status; WAIT_D1: status held, expecting data byte 1;
  // WAIT_D2: data byte 1 captured, expecting data byte 2.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parse_state_t;

  // Number of data bytes that follow a channel status byte.
  function automatic logic [1:0] data_len(input logic [3:0] nib);
    logic [1:0] len;
    case (nib)
      PROG, CH_AT: len = 2'd1;
      default:     len = 2'd2;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: turns a MIDI byte stream into monophonic, last-note-priority
// note events for the envelope, oscillator and amplitude stages.
// Parameters:
//   CHANNEL  channel (0..15) accepted when OMNI = 0
//   OMNI     1 = accept channel messages on every channel
// Ports:
//   clk48m    in   system clock
//   rst       in   asynchronous, active-high reset
//   rx_data   in   8-bit received byte, qualified by rx_valid
//   rx_valid  in   one-cycle strobe per received byte
//   trigger   out  one-cycle pulse on note start / retrigger
//   dehold    out  one-cycle pulse on release of the sounding note
//   gate      out  high while a note is held
//   note      out  current note number
//   velocity  out  velocity of the current note
module midi_note_ctrl
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter logic       OMNI    = 1'b0
) (
  input  logic       clk48m,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       trigger,
  output logic       dehold,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  parse_state_t state;
  logic [7:0]   status;
  logic [6:0]   d1;

  logic         ch_ok;
  logic         msg_done;
  logic         note_start;
  logic         note_release;
  logic [3:0]   nib;
  logic [6:0]   d2;

  // Decode the message being completed by the current byte into note actions.
  // Only two-byte messages ever affect the outputs, so completion is only
  // tracked in WAIT_D2; one-byte messages are consumed silently by the parser.
  always_comb begin
    nib          = status[7:4];
    d2           = rx_data[6:0];
    ch_ok        = OMNI || (status[3:0] == CHANNEL);
    msg_done     = rx_valid && !rx_data[7] && (state == WAIT_D2) && ch_ok;
    note_start   = 1'b0;
    note_release = 1'b0;
    if (msg_done) begin
      if ((nib == NOTE_ON) && (d2 != 7'd0)) begin
        note_start = 1'b1;
      end else if (((nib == NOTE_ON) || (nib == NOTE_OFF)) && gate && (d1 == note)) begin
        // Release only the note that is actually sounding (last-note priority).
        note_release = 1'b1;
      end else if ((nib == CC) && gate &&
                   ((d1 == CC_ALL_NOTES_OFF) || (d1 == CC_ALL_SOUND_OFF))) begin
        note_release = 1'b1;
      end else begin
        note_start   = 1'b0;
        note_release = 1'b0;
      end
    end else begin
      note_start   = 1'b0;
      note_release = 1'b0;
    end
  end

  // Parser state, running status, captured data and registered note outputs.
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      status   <= 8'h00;
      d1       <= 7'd0;
      trigger  <= 1'b0;
      dehold   <= 1'b0;
      gate     <= 1'b0;
      note     <= 7'd0;
      velocity <= 7'd0;
    end else begin
      trigger <= note_start;
      dehold  <= note_release;
      if (note_start) begin
        gate     <= 1'b1;
        note     <= d1;
        velocity <= d2;
      end else if (note_release) begin
        gate <= 1'b0;
      end else begin
        gate <= gate;
      end

      if (rx_valid) begin
        if (rx_data >= RT_MIN) begin
          // Real-time bytes pass through without disturbing a message.
          state <= state;
        end else if (rx_data >= SYS_MIN) begin
          // System common drops running status; later data is discarded.
          state <= IDLE;
        end else if (rx_data[7]) begin
          status <= rx_data;
          state  <= WAIT_D1;
        end else begin
          case (state)
            IDLE: state <= IDLE;
            WAIT_D1: begin
              if (data_len(status[7:4]) == 2'd2) begin
                d1    <= rx_data[6:0];
                state <= WAIT_D2;
              end else begin
                state <= WAIT_D1;
              end
            end
            WAIT_D2: state <= WAIT_D1;
            default: state <= IDLE;
          endcase
        end
      end else begin
        state <= state;
      end
    end
  end

endmodule
